// File: rtl/game_sequencer.sv
// Game sequencer: INIT/RUN/LOSE control, physics/scroll tick dividers, BCD score and high score.
// Latency: every output is registered one cycle after its cause; no backpressure. Optional pause state via GAME_PAUSE_EN.
module game_sequencer #(
    parameter int PHYS_DIV   = 2097152,
    parameter int SCROLL_DIV = 1048576
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Collide,
    input  logic       Pipe_Passed,
`ifdef GAME_PAUSE_EN
    input  logic       Pause,
    output logic       Q_Pause,
`endif
    output logic       Q_Initial,
    output logic       Q_Run,
    output logic       Q_Lose,
    output logic       Phys_Tick,
    output logic       Scroll_Tick,
    output logic [3:0] Score_Ones,
    output logic [3:0] Score_Tens,
    output logic [3:0] High_Ones,
    output logic [3:0] High_Tens
);

    localparam int CW = 22;
    localparam logic [CW-1:0] PHYS_LAST   = CW'(PHYS_DIV - 1);
    localparam logic [CW-1:0] SCROLL_LAST = CW'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_LOSE  = 2'd2
`ifdef GAME_PAUSE_EN
        ,
        S_PAUSE = 2'd3
`endif
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] phys_cnt;
    logic [CW-1:0] scroll_cnt;
    logic          advance;
    logic          score_inc;

    always_comb begin
        nxt = state;
        case (state)
            S_INIT: if (Start) nxt = S_RUN;
            S_RUN: begin
                if (Collide) nxt = S_LOSE;
`ifdef GAME_PAUSE_EN
                else if (Pause) nxt = S_PAUSE;
`endif
            end
            S_LOSE: if (Ack) nxt = S_INIT;
`ifdef GAME_PAUSE_EN
            S_PAUSE: if (Pause) nxt = S_RUN;
`endif
            default: nxt = S_INIT;
        endcase
    end

    // Dividers only advance on cycles that stay in RUN, so leaving RUN freezes the phase
    // and a tick can never land on the first cycle of another state.
    assign advance   = (state == S_RUN) && (nxt == S_RUN);
    assign score_inc = (state == S_RUN) && !Collide && Pipe_Passed;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_INIT;
            Q_Initial   <= 1'b1;
            Q_Run       <= 1'b0;
            Q_Lose      <= 1'b0;
`ifdef GAME_PAUSE_EN
            Q_Pause     <= 1'b0;
`endif
            Phys_Tick   <= 1'b0;
            Scroll_Tick <= 1'b0;
            phys_cnt    <= '0;
            scroll_cnt  <= '0;
            Score_Ones  <= 4'd0;
            Score_Tens  <= 4'd0;
            High_Ones   <= 4'd0;
            High_Tens   <= 4'd0;
        end else begin
            state       <= nxt;
            Q_Initial   <= (nxt == S_INIT);
            Q_Run       <= (nxt == S_RUN);
            Q_Lose      <= (nxt == S_LOSE);
`ifdef GAME_PAUSE_EN
            Q_Pause     <= (nxt == S_PAUSE);
`endif
            Phys_Tick   <= advance && (phys_cnt == PHYS_LAST);
            Scroll_Tick <= advance && (scroll_cnt == SCROLL_LAST);

            if ((state == S_INIT) && Start) begin
                phys_cnt   <= '0;
                scroll_cnt <= '0;
                Score_Ones <= 4'd0;
                Score_Tens <= 4'd0;
            end else begin
                if (advance) begin
                    phys_cnt   <= (phys_cnt == PHYS_LAST) ? '0 : phys_cnt + CW'(1);
                    scroll_cnt <= (scroll_cnt == SCROLL_LAST) ? '0 : scroll_cnt + CW'(1);
                end
                if (score_inc && !((Score_Tens == 4'd9) && (Score_Ones == 4'd9))) begin
                    if (Score_Ones == 4'd9) begin
                        Score_Ones <= 4'd0;
                        Score_Tens <= Score_Tens + 4'd1;
                    end else begin
                        Score_Ones <= Score_Ones + 4'd1;
                    end
                end
            end

            // BCD digits order the same as binary, so a packed compare is a numeric compare.
            if ((state == S_RUN) && (nxt == S_LOSE) &&
                ({Score_Tens, Score_Ones} > {High_Tens, High_Ones})) begin
                High_Tens <= Score_Tens;
                High_Ones <= Score_Ones;
            end
        end
    end

endmodule
